// File: rtl/otter_intr_ctrl.sv
// ----------------------------------------------------------------------------
// otter_intr_ctrl
//
// Interrupt controller for the OTTER MCU.
// - Synchronizes up to NUM_SRC asynchronous interrupt lines.
// - Latches edge-mode sources into PEND.
// - Selects the lowest-index enabled pending source.
// - Hands the interrupt to the control FSM with a one-cycle INT_TAKEN strobe.
//   The CSR file uses this strobe to capture MEPC and clear MIE.
//
// Ports
//   CLK            system clock, rising edge
//   RST_N          synchronous active-low reset
//   IRQ            raw interrupt lines (asynchronous to CLK)
//   CSR_MIE        global interrupt enable from the CSR file
//   INSTR_BOUNDARY control FSM can accept a trap this cycle
//   MRET           mret executed (one-cycle pulse)
//   CFG_WE         configuration write strobe
//   CFG_ADDR       0 MASK, 1 PEND (W1C), 2 MODE, 3 STATUS
//   CFG_WD         configuration write data
//   CFG_RD         configuration read data (combinational on CFG_ADDR)
//   INT_REQ        an interrupt is ready to be taken
//   INT_TAKEN      one-cycle interrupt entry strobe
//   INT_ID         ID of the last source taken
//   IN_SERVICE     a handler is active
// ----------------------------------------------------------------------------
module otter_intr_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int IDW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic               CSR_MIE,
    input  logic               INSTR_BOUNDARY,
    input  logic               MRET,
    input  logic               CFG_WE,
    input  logic [1:0]         CFG_ADDR,
    input  logic [31:0]        CFG_WD,
    output logic [31:0]        CFG_RD,
    output logic               INT_REQ,
    output logic               INT_TAKEN,
    output logic [IDW-1:0]     INT_ID,
    output logic               IN_SERVICE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_SRC-1:0] sync_meta, sync_q, sync_prev;
    logic [NUM_SRC-1:0] mask_q, mode_q, pend_edge_q;
    logic [NUM_SRC-1:0] pend, eligible, rise, w1c, take_clr;
    logic [IDW-1:0]     id_q, winner;
    logic               req, take;
    logic               unused_cfg_wd;

    // Configuration bits above NUM_SRC are deliberately discarded.
    assign unused_cfg_wd = ^CFG_WD;

    // Two-flop synchronizer plus a third stage that remembers the previous
    // synchronized value for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_meta <= '0;
            sync_q    <= '0;
            sync_prev <= '0;
        end else begin
            sync_meta <= IRQ;
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
        end
    end

    // Edge-mode sources use the latched bit.
    // Level-mode sources follow the synchronized line directly.
    assign rise     = sync_q & ~sync_prev & mode_q;
    assign pend     = (pend_edge_q & mode_q) | (sync_q & ~mode_q);
    assign eligible = pend & mask_q;
    assign w1c      = (CFG_WE && CFG_ADDR == 2'd1) ? CFG_WD[NUM_SRC-1:0] : '0;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDW'(i);
            end
        end
    end

    assign req  = (state == IDLE) && (|eligible) && CSR_MIE;
    assign take = req && INSTR_BOUNDARY;

    // A taken edge-mode source loses its pending bit at the capture edge.
    always_comb begin
        take_clr = '0;
        if (take) begin
            take_clr[winner] = 1'b1;
        end
    end

    // Configuration registers and edge-mode pending latch.
    // A new edge overrides a simultaneous W1C or take-clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mask_q      <= '0;
            mode_q      <= '0;
            pend_edge_q <= '0;
        end else begin
            if (CFG_WE && CFG_ADDR == 2'd0) begin
                mask_q <= CFG_WD[NUM_SRC-1:0];
            end
            if (CFG_WE && CFG_ADDR == 2'd2) begin
                mode_q <= CFG_WD[NUM_SRC-1:0];
            end
            pend_edge_q <= ((pend_edge_q & ~w1c & ~take_clr) | rise) & mode_q;
        end
    end

    // State register and captured interrupt ID.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            id_q  <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                id_q <= winner;
            end
        end
    end

    // Entry sequencing: IDLE -> TAKE (one cycle) -> SERVICE until mret.
    // No new take is possible outside IDLE, so handlers never nest.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = TAKE;
            TAKE:    state_next = SERVICE;
            SERVICE: if (MRET) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are qualified with RST_N so that asserting reset mid-TAKE
    // suppresses the strobe in that same cycle rather than one edge later.
    assign INT_REQ    = req && RST_N;
    assign INT_TAKEN  = (state == TAKE) && RST_N;
    assign IN_SERVICE = (state == SERVICE) && RST_N;
    assign INT_ID     = RST_N ? id_q : '0;

    // Register readback; unimplemented upper bits read as zero.
    always_comb begin
        CFG_RD = '0;
        if (RST_N) begin
            case (CFG_ADDR)
                2'd0: CFG_RD[NUM_SRC-1:0] = mask_q;
                2'd1: CFG_RD[NUM_SRC-1:0] = pend;
                2'd2: CFG_RD[NUM_SRC-1:0] = mode_q;
                default: begin
                    CFG_RD[0]           = IN_SERVICE;
                    CFG_RD[2:1]         = state;
                    CFG_RD[8+IDW-1:8]   = id_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_otter_intr_ctrl
//
// Self-checking bench for otter_intr_ctrl (NUM_SRC = 8).
// Expected interrupt IDs are queued when a boundary is driven.
// A negedge monitor pops and compares them whenever INT_TAKEN fires.
// Inputs change 1 time unit after the rising edge; checks happen there or
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_otter_intr_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  IRQ;
    logic        CSR_MIE;
    logic        INSTR_BOUNDARY;
    logic        MRET;
    logic        CFG_WE;
    logic [1:0]  CFG_ADDR;
    logic [31:0] CFG_WD;
    logic [31:0] CFG_RD;
    logic        INT_REQ;
    logic        INT_TAKEN;
    logic [2:0]  INT_ID;
    logic        IN_SERVICE;

    int checks = 0;
    int errors = 0;
    int take_count = 0;
    int take_q[$];

    otter_intr_ctrl #(.NUM_SRC(8)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .IRQ            (IRQ),
        .CSR_MIE        (CSR_MIE),
        .INSTR_BOUNDARY (INSTR_BOUNDARY),
        .MRET           (MRET),
        .CFG_WE         (CFG_WE),
        .CFG_ADDR       (CFG_ADDR),
        .CFG_WD         (CFG_WD),
        .CFG_RD         (CFG_RD),
        .INT_REQ        (INT_REQ),
        .INT_TAKEN      (INT_TAKEN),
        .INT_ID         (INT_ID),
        .IN_SERVICE     (IN_SERVICE)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] irq, input logic boundary, input logic mret, input logic mie);
        IRQ            = irq;
        INSTR_BOUNDARY = boundary;
        MRET           = mret;
        CSR_MIE        = mie;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
        CFG_WE   = 1'b1;
        CFG_ADDR = addr;
        CFG_WD   = data;
        tick();
        CFG_WE   = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        CFG_ADDR = addr;
        #1;
        checkOutput(tag, CFG_RD, exp);
    endtask

    // Scoreboard monitor: every INT_TAKEN cycle must match a queued ID.
    always @(negedge CLK) begin
        if (INT_TAKEN === 1'b1) begin
            take_count++;
            if (take_q.size() == 0) begin
                checkOutput("unexpected_take", 32'd1, 32'd0);
            end else begin
                checkOutput("take_id", 32'(INT_ID), 32'(take_q.pop_front()));
            end
        end
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int takes_before;

        RST_N    = 1'b0;
        CFG_WE   = 1'b0;
        CFG_ADDR = 2'd0;
        CFG_WD   = '0;
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1);

        // Reset values with all interrupt lines and boundary asserted.
        repeat (4) tick();
        checkOutput("rst_int_req", 32'(INT_REQ), 32'd0);
        checkOutput("rst_int_taken", 32'(INT_TAKEN), 32'd0);
        checkOutput("rst_in_service", 32'(IN_SERVICE), 32'd0);
        checkOutput("rst_int_id", 32'(INT_ID), 32'd0);
        for (int a = 0; a < 4; a++) begin
            checkReg($sformatf("rst_cfg_rd%0d", a), 2'(a), 32'd0);
        end

        // Release with MASK=0: level PEND follows the lines, no request.
        RST_N = 1'b1;
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        checkOutput("mask0_int_req", 32'(INT_REQ), 32'd0);
        checkReg("level_pend_ff", 2'd1, 32'h0000_00FF);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        // Edge take on source 3 with a two-cycle pulse.
        cfgWrite(2'd2, 32'h08);
        cfgWrite(2'd0, 32'h08);
        checkReg("mask_rd", 2'd0, 32'h08);
        applyStimulus(8'h08, 1'b0, 1'b0, 1'b1);
        tick();
        checkReg("edge_pend_c1", 2'd1, 32'h00);
        tick();
        IRQ = 8'h00;
        checkReg("edge_pend_c2", 2'd1, 32'h00);
        checkOutput("edge_req_c2", 32'(INT_REQ), 32'd0);
        tick();
        checkReg("edge_pend_c3", 2'd1, 32'h08);
        checkOutput("edge_req_c3", 32'(INT_REQ), 32'd1);
        take_q.push_back(3);
        INSTR_BOUNDARY = 1'b1;
        tick();
        INSTR_BOUNDARY = 1'b0;
        checkOutput("edge_taken", 32'(INT_TAKEN), 32'd1);
        checkOutput("edge_id", 32'(INT_ID), 32'd3);
        checkReg("edge_pend_clr", 2'd1, 32'h00);
        tick();
        checkOutput("edge_taken_1cyc", 32'(INT_TAKEN), 32'd0);
        checkOutput("edge_in_service", 32'(IN_SERVICE), 32'd1);
        checkReg("edge_status", 2'd3, 32'h0000_0305);
        MRET = 1'b1;
        tick();
        MRET = 1'b0;
        checkOutput("mret_in_service", 32'(IN_SERVICE), 32'd0);
        checkOutput("mret_id_held", 32'(INT_ID), 32'd3);

        // Priority in level mode and no nesting while in service.
        IRQ = 8'b1010_0100;
        cfgWrite(2'd2, 32'h00);
        cfgWrite(2'd0, 32'hFF);
        tick();
        checkReg("prio_pend", 2'd1, 32'hA4);
        checkOutput("prio_req", 32'(INT_REQ), 32'd1);
        takes_before = take_count;
        take_q.push_back(2);
        INSTR_BOUNDARY = 1'b1;
        repeat (4) tick();
        checkOutput("nest_in_service", 32'(IN_SERVICE), 32'd1);
        checkOutput("nest_req_low", 32'(INT_REQ), 32'd0);
        INSTR_BOUNDARY = 1'b0;
        checkOutput("nest_take_count", 32'(take_count - takes_before), 32'd1);
        MRET = 1'b1;
        tick();
        MRET = 1'b0;
        checkOutput("post_mret_req", 32'(INT_REQ), 32'd1);
        take_q.push_back(2);
        INSTR_BOUNDARY = 1'b1;
        tick();
        INSTR_BOUNDARY = 1'b0;
        checkOutput("retake_id2", 32'(INT_ID), 32'd2);
        IRQ = 8'b1010_0000;
        repeat (3) tick();
        MRET = 1'b1;
        tick();
        MRET = 1'b0;
        take_q.push_back(5);
        INSTR_BOUNDARY = 1'b1;
        tick();
        INSTR_BOUNDARY = 1'b0;
        checkOutput("take_id5", 32'(INT_ID), 32'd5);
        tick();
        MRET = 1'b1;
        tick();
        MRET = 1'b0;

        // MIE gating, then combinational re-enable.
        CSR_MIE = 1'b0;
        #1;
        checkOutput("mie0_req", 32'(INT_REQ), 32'd0);
        takes_before = take_count;
        INSTR_BOUNDARY = 1'b1;
        repeat (2) tick();
        INSTR_BOUNDARY = 1'b0;
        checkOutput("mie0_no_take", 32'(take_count - takes_before), 32'd0);
        checkOutput("mie0_no_service", 32'(IN_SERVICE), 32'd0);
        CSR_MIE = 1'b1;
        #1;
        checkOutput("mie1_req", 32'(INT_REQ), 32'd1);
        IRQ = 8'h00;
        repeat (3) tick();

        // W1C colliding with a new edge: the set wins.
        cfgWrite(2'd2, 32'h02);
        IRQ = 8'h02;
        repeat (3) tick();
        checkReg("w1c_pend_set", 2'd1, 32'h02);
        IRQ = 8'h00;
        repeat (3) tick();
        IRQ = 8'h02;
        repeat (2) tick();
        cfgWrite(2'd1, 32'h02);
        checkReg("w1c_set_wins", 2'd1, 32'h02);
        cfgWrite(2'd1, 32'h02);
        checkReg("w1c_clears", 2'd1, 32'h00);
        IRQ = 8'h00;
        repeat (3) tick();

        // Reset asserted in the TAKE cycle.
        IRQ = 8'h02;
        repeat (3) tick();
        checkOutput("rst_mid_req", 32'(INT_REQ), 32'd1);
        takes_before = take_count;
        INSTR_BOUNDARY = 1'b1;
        tick();
        INSTR_BOUNDARY = 1'b0;
        RST_N = 1'b0;
        #1;
        checkOutput("rst_mid_no_taken", 32'(INT_TAKEN), 32'd0);
        tick();
        checkOutput("rst_mid_in_service", 32'(IN_SERVICE), 32'd0);
        checkOutput("rst_mid_id", 32'(INT_ID), 32'd0);
        RST_N = 1'b1;
        tick();
        checkOutput("rst_mid_no_pulse", 32'(take_count - takes_before), 32'd0);
        checkReg("rst_mid_mask", 2'd0, 32'h00);
        checkReg("rst_mid_status", 2'd3, 32'h00);

        // Stray MRET in IDLE changes nothing; the controller still works.
        cfgWrite(2'd0, 32'hFF);
        MRET = 1'b1;
        tick();
        MRET = 1'b0;
        checkReg("stray_mret_status", 2'd3, 32'h00);
        checkOutput("stray_mret_req", 32'(INT_REQ), 32'd1);
        take_q.push_back(1);
        INSTR_BOUNDARY = 1'b1;
        tick();
        INSTR_BOUNDARY = 1'b0;
        tick();
        checkReg("final_status", 2'd3, 32'h0000_0105);
        checkOutput("take_q_empty", 32'(take_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
